// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment glyph table, scan phase type and BCD decode helper.
package seg7_pkg;
  typedef enum logic {PH_GUARD, PH_ON} phase_e;
  localparam logic [6:0] SEG_GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    return code < 4'd10 ? SEG_GLYPH[code] : SEG_DASH;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: glyph lookup with dp, blanking, lamp test and output polarity.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] code,
  input  logic       dp,
  input  logic       en,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [7:0] seg
);
  logic [7:0] raw;
  // lamp_test wins over blanking but never over the slot enable (guard interval)
  assign raw = !en ? {1'b0, SEG_OFF} : lamp_test ? 8'hFF : blank ? {1'b0, SEG_OFF} : {dp, bcd_to_seg(code)};
  assign seg = ACTIVE_LOW ? ~raw : raw;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 6-digit multiplexed 7-segment scanner with per-frame snapshot and guard blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DIGITS         = 6,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data,
  input  logic [5:0]  dp_mask,
  input  logic        lz_en,
  input  logic        freeze,
  input  logic        lamp_test,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame_start,
  output logic [2:0]  digit_idx
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [5:0] SEL_IDLE = SEL_ACTIVE_LOW != 0 ? 6'h3F : 6'h00;

  generate
    if (BLANK_CYCLES >= TICK_DIV || DIGITS != 6) begin : g_bad_params
      $error("seg7_scan_driver: BLANK_CYCLES must be < CLK_HZ/SCAN_HZ and DIGITS must be 6");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d;
  logic          frame_q, frame_d;
  logic [7:0]    seg_q, seg_d, dec_seg;
  logic [5:0]    sel_q, sel_d;
  logic          wrap, lz_hit;
  logic [3:0]    digit;
  phase_e        phase;

  assign wrap   = cnt_q == CW'(TICK_DIV - 1);
  assign phase  = cnt_q < CW'(BLANK_CYCLES) ? PH_GUARD : PH_ON;
  assign digit  = shadow_q[{idx_q, 2'b00} +: 4];
  assign lz_hit = lz_en && idx_q == 3'd5 && digit == 4'd0;

  seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_decode (
    .code      (digit),
    .dp        (dp_mask[idx_q]),
    .en        (phase == PH_ON),
    .blank     (lz_hit),
    .lamp_test (lamp_test),
    .seg       (dec_seg)
  );

  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = !wrap ? idx_q : idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
    frame_d  = wrap && idx_q == 3'd5;
    shadow_d = frame_d && !freeze ? data : shadow_q;
    seg_d    = dec_seg;
    // the select stays active on a suppressed leading zero to keep duty uniform
    sel_d    = phase == PH_ON ? SEL_IDLE ^ (6'b1 << idx_q) : SEL_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_IDLE;
      sel_q    <= SEL_IDLE;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign seg         = seg_q;
  assign sel         = sel_q;
  assign frame_start = frame_q;
  assign digit_idx   = idx_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-by-frame vector table plus async reset sequence for seg7_scan_driver.
module tb_seg7_scan_driver;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [23:0] data = '0;
  logic [5:0]  dp_mask = '0;
  logic        lz_en = 1'b0, freeze = 1'b0, lamp_test = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_start;
  logic [2:0]  digit_idx;
  int checks = 0, failures = 0;

  typedef struct {
    logic [23:0]       data;
    logic [5:0]        dp;
    logic              lz;
    logic              lamp;
    logic              frz;
    logic [0:5][7:0]   e;
  } vec_t;
  vec_t vec [8];

  seg7_scan_driver #(
    .CLK_HZ(100), .SCAN_HZ(10), .DIGITS(6), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask), .lz_en(lz_en),
    .freeze(freeze), .lamp_test(lamp_test), .seg(seg), .sel(sel),
    .frame_start(frame_start), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Steps one full frame from offset 0; output at offset o reflects counter state o-1.
  task automatic run_frame(input int f, input logic [0:5][7:0] e);
    int d, ph;
    logic [5:0] exp_sel;
    for (int o = 1; o <= 60; o++) begin
      @(negedge clk);
      d = (o - 1) / 10;
      ph = (o - 1) % 10;
      exp_sel = ~(6'b1 << d);
      if (ph < 2) begin
        chk($sformatf("f%0d o%0d guard seg", f, o), {16'h0, seg}, 24'hFF);
        chk($sformatf("f%0d o%0d guard sel", f, o), {18'h0, sel}, 24'h3F);
      end else begin
        chk($sformatf("f%0d o%0d d%0d seg", f, o, d), {16'h0, seg}, {16'h0, e[d]});
        chk($sformatf("f%0d o%0d d%0d sel", f, o, d), {18'h0, sel}, {18'h0, exp_sel});
      end
      chk($sformatf("f%0d o%0d digit_idx", f, o), {21'h0, digit_idx}, 24'((o % 60) / 10));
      chk($sformatf("f%0d o%0d frame_start", f, o), {23'h0, frame_start}, {23'h0, o == 60});
    end
  endtask

  initial begin
    vec[0] = '{24'h123456, 6'h00, 1'b0, 1'b0, 1'b0, {6{8'hC0}}};
    vec[1] = '{24'h235959, 6'h00, 1'b0, 1'b0, 1'b0, {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}};
    vec[2] = '{24'h111111, 6'h00, 1'b0, 1'b0, 1'b1, {8'h90, 8'h92, 8'h90, 8'h92, 8'hB0, 8'hA4}};
    vec[3] = '{24'h111111, 6'h00, 1'b0, 1'b0, 1'b0, {8'h90, 8'h92, 8'h90, 8'h92, 8'hB0, 8'hA4}};
    vec[4] = '{24'h0A5959, 6'h00, 1'b1, 1'b0, 1'b0, {6{8'hF9}}};
    vec[5] = '{24'h0A5959, 6'b010100, 1'b1, 1'b0, 1'b0, {8'h90, 8'h92, 8'h10, 8'h92, 8'h3F, 8'hFF}};
    vec[6] = '{24'h0A5959, 6'b010100, 1'b1, 1'b1, 1'b0, {6{8'h00}}};
    vec[7] = '{24'h0A5959, 6'h00, 1'b0, 1'b0, 1'b0, {8'h90, 8'h92, 8'h90, 8'h92, 8'hBF, 8'hC0}};

    repeat (3) @(negedge clk);
    chk("reset seg", {16'h0, seg}, 24'hFF);
    chk("reset sel", {18'h0, sel}, 24'h3F);
    chk("reset frame_start", {23'h0, frame_start}, 24'h0);
    chk("reset digit_idx", {21'h0, digit_idx}, 24'h0);
    rst_n = 1'b1;

    // Inputs are applied at offset 0: live ones affect this frame, data loads at its end.
    for (int i = 0; i < 8; i++) begin
      data = vec[i].data;
      dp_mask = vec[i].dp;
      lz_en = vec[i].lz;
      lamp_test = vec[i].lamp;
      freeze = vec[i].frz;
      run_frame(i, vec[i].e);
    end

    repeat (15) @(negedge clk);
    chk("pre-reset d1 seg", {16'h0, seg}, 24'h92);
    chk("pre-reset d1 sel", {18'h0, sel}, 24'h3D);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset seg", {16'h0, seg}, 24'hFF);
    chk("async reset sel", {18'h0, sel}, 24'h3F);
    chk("async reset digit_idx", {21'h0, digit_idx}, 24'h0);
    chk("async reset frame_start", {23'h0, frame_start}, 24'h0);
    @(negedge clk);
    chk("held reset seg", {16'h0, seg}, 24'hFF);
    chk("held reset sel", {18'h0, sel}, 24'h3F);
    rst_n = 1'b1;
    run_frame(8, {6{8'hC0}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
